// File: rtl/uart_lite_sched_if.sv
// AXI4-Lite bundle (32-bit address/data) between the UART scheduler and the
// AXI UART Lite slave.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/uart_lite_sched.sv
// uart_lite_sched: sole AXI-Lite master in front of an AXI UART Lite.
// Round-robin arbitrates byte writes from NUM_REQ clients, gates every write
// on a fresh status read (TX FIFO full bit), and keeps one transaction in
// flight at a time.
// Optional RX drain into a one-entry holding register: define UART_SCHED_RX_EN.
// Without it the RX path is absent and status is only polled on demand.
module uart_lite_sched #(
  parameter int          NUM_REQ       = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int          POLL_INTERVAL = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  input  logic                 rx_ready,
  AXI_LITE.Master              axi,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'h4;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h8;

`ifdef UART_SCHED_RX_EN
  localparam logic [31:0] RX_ADDR   = BASE_ADDR;
  localparam int          CW        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  typedef enum logic [2:0] {
    S_IDLE, S_STAT_AR, S_STAT_R, S_TX_AWW, S_TX_B, S_RX_AR, S_RX_R
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STAT_AR, S_STAT_R, S_TX_AWW, S_TX_B
  } state_e;
`endif

  state_e               state_q, state_d;
  logic                 aw_valid_q, aw_valid_d;
  logic                 w_valid_q, w_valid_d;
  logic                 b_ready_q, b_ready_d;
  logic                 ar_valid_q, ar_valid_d;
  logic                 r_ready_q, r_ready_d;
  logic [31:0]          aw_addr_q, aw_addr_d;
  logic [31:0]          ar_addr_q, ar_addr_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 err_q, err_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        gnt_q, gnt_d;
`ifdef UART_SCHED_RX_EN
  logic                 rx_valid_q, rx_valid_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic [CW-1:0]        poll_cnt_q, poll_cnt_d;
`endif

  logic                 gnt_found;
  logic [PW-1:0]        gnt_idx;
  logic [7:0]           gnt_byte;
  logic [PW-1:0]        rr_next;
  logic                 err_set;
  logic [7:0]           stat;

  // status byte is consumed straight off the R channel so the decision
  // costs no extra cycle
  assign stat = axi.r_data[7:0];

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest
  // valid index overall (wrap). Descending scan leaves the lowest hit.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_byte  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
        gnt_byte  = req_data[8*i +: 8];
      end
    end
    if (!gnt_found) begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = PW'(i);
          gnt_byte  = req_data[8*i +: 8];
        end
      end
    end
  end

  assign rr_next = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;

  // Next-state and next-output computation for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    aw_addr_d   = aw_addr_q;
    ar_addr_d   = ar_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    req_ready_d = '0;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    err_set     = 1'b0;
`ifdef UART_SCHED_RX_EN
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    poll_cnt_d  = poll_cnt_q;
    // consumer pop; a new RX read is only started while empty, so this
    // never races with the fill below
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d    = S_STAT_AR;
          ar_valid_d = 1'b1;
          ar_addr_d  = STAT_ADDR;
`ifdef UART_SCHED_RX_EN
          poll_cnt_d = '0;
        end else if (poll_cnt_q == CW'(POLL_INTERVAL-1)) begin
          state_d    = S_STAT_AR;
          ar_valid_d = 1'b1;
          ar_addr_d  = STAT_ADDR;
          poll_cnt_d = '0;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
`endif
        end
      end

      S_STAT_AR: begin
        if (axi.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_STAT_R;
        end
      end

      S_STAT_R: begin
        if (axi.r_valid) begin
          r_ready_d = 1'b0;
          err_set   = (axi.r_resp != 2'b00);
`ifdef UART_SCHED_RX_EN
          if (stat[0] && !rx_valid_q) begin
            state_d    = S_RX_AR;
            ar_valid_d = 1'b1;
            ar_addr_d  = RX_ADDR;
          end else
`endif
          if (!stat[3] && gnt_found) begin
            state_d    = S_TX_AWW;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = TX_ADDR;
            w_data_d   = {24'h0, gnt_byte};
            w_strb_d   = 4'b0001;
            gnt_d      = gnt_idx;
            rr_ptr_d   = rr_next;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_TX_AWW: begin
        // AW and W complete independently; move on once both are done
        if (axi.aw_ready) aw_valid_d = 1'b0;
        if (axi.w_ready)  w_valid_d  = 1'b0;
        if ((!aw_valid_q || axi.aw_ready) && (!w_valid_q || axi.w_ready)) begin
          state_d   = S_TX_B;
          b_ready_d = 1'b1;
        end
      end

      S_TX_B: begin
        if (axi.b_valid) begin
          b_ready_d = 1'b0;
          err_set   = (axi.b_resp != 2'b00);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == PW'(i)) req_ready_d[i] = 1'b1;
          end
          // re-poll straight away: the FIFO may have filled
          state_d    = S_STAT_AR;
          ar_valid_d = 1'b1;
          ar_addr_d  = STAT_ADDR;
        end
      end

`ifdef UART_SCHED_RX_EN
      S_RX_AR: begin
        if (axi.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RX_R;
        end
      end

      S_RX_R: begin
        if (axi.r_valid) begin
          r_ready_d  = 1'b0;
          err_set    = (axi.r_resp != 2'b00);
          rx_data_d  = axi.r_data[7:0];
          rx_valid_d = 1'b1;
          state_d    = S_STAT_AR;
          ar_valid_d = 1'b1;
          ar_addr_d  = STAT_ADDR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // a new error wins over a same-cycle clear
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // All FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      req_ready_q <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
`ifdef UART_SCHED_RX_EN
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      req_ready_q <= req_ready_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
`ifdef UART_SCHED_RX_EN
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign axi.aw_valid = aw_valid_q;
  assign axi.aw_addr  = aw_addr_q;
  assign axi.aw_prot  = 3'b000;
  assign axi.w_valid  = w_valid_q;
  assign axi.w_data   = w_data_q;
  assign axi.w_strb   = w_strb_q;
  assign axi.b_ready  = b_ready_q;
  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_prot  = 3'b000;
  assign axi.r_ready  = r_ready_q;
  assign req_ready    = req_ready_q;
  assign err          = err_q;

`ifdef UART_SCHED_RX_EN
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_valid = 1'b0;
  assign rx_data  = 8'h00;
`endif

  // status/data bits this build does not look at
  logic unused_sink;
  assign unused_sink = ^{axi.r_data, rx_ready};

endmodule

// File: tb/tb_uart_lite_sched.sv
// Bench for uart_lite_sched: behavioural AXI UART Lite slave, client driver,
// and a scoreboard of expected writes (client, byte) in grant order.
module tb_uart_lite_sched;
  localparam int          NR   = 4;
  localparam logic [31:0] BASE = 32'h4060_0000;
  localparam int          PI   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            err;
  logic            err_clr;

  AXI_LITE axi();

  uart_lite_sched #(.NUM_REQ(NR), .BASE_ADDR(BASE), .POLL_INTERVAL(PI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .axi(axi), .err(err), .err_clr(err_clr)
  );

  // slave configuration, written only by the test sequence
  logic       aw_rdy_en = 1'b1;
  logic       w_rdy_en  = 1'b1;
  logic [1:0] bresp_cfg = 2'b00;
  int         full_until = 0;   // status reads with index below this report TX full
  int         rx_target  = 0;   // RX reads with index below this see data waiting
  logic [7:0] rx_byte    = 8'h00;

  // slave state, written only by the slave process
  logic        s_r_valid = 1'b0, s_b_valid = 1'b0;
  logic [31:0] s_r_data = '0;
  logic [1:0]  s_b_resp = '0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  int          stat_rd_cnt = 0, rx_rd_cnt = 0, wr_cnt = 0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, bad_addr_cnt = 0;
  logic [31:0] last_aw_addr = '0, last_w_data = '0;
  logic [3:0]  last_w_strb = '0;

  assign axi.ar_ready = 1'b1;
  assign axi.aw_ready = aw_rdy_en;
  assign axi.w_ready  = w_rdy_en;
  assign axi.r_valid  = s_r_valid;
  assign axi.r_data   = s_r_data;
  assign axi.r_resp   = 2'b00;
  assign axi.b_valid  = s_b_valid;
  assign axi.b_resp   = s_b_resp;

  wire aw_hs = axi.aw_valid && axi.aw_ready;
  wire w_hs  = axi.w_valid && axi.w_ready;

  // zero-wait UART Lite model
  always @(posedge clk) begin
    if (!rst_n) begin
      s_r_valid <= 1'b0;
      s_b_valid <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
    end else begin
      if (s_r_valid && axi.r_ready) s_r_valid <= 1'b0;
      if (axi.ar_valid && axi.ar_ready) begin
        s_r_valid <= 1'b1;
        if (axi.ar_addr == BASE + 32'h8) begin
          s_r_data    <= {28'h0, (stat_rd_cnt < full_until), 2'b00, (rx_rd_cnt < rx_target)};
          stat_rd_cnt <= stat_rd_cnt + 1;
        end else if (axi.ar_addr == BASE) begin
          s_r_data  <= {24'h0, rx_byte};
          rx_rd_cnt <= rx_rd_cnt + 1;
        end else begin
          s_r_data     <= 32'hDEAD_BEEF;
          bad_addr_cnt <= bad_addr_cnt + 1;
        end
      end
      if (aw_hs) begin aw_hs_cnt <= aw_hs_cnt + 1; last_aw_addr <= axi.aw_addr; end
      if (w_hs) begin w_hs_cnt <= w_hs_cnt + 1; last_w_data <= axi.w_data; last_w_strb <= axi.w_strb; end
      if (s_b_valid && axi.b_ready) s_b_valid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got    <= 1'b0;
        w_got     <= 1'b0;
        s_b_valid <= 1'b1;
        s_b_resp  <= bresp_cfg;
        wr_cnt    <= wr_cnt + 1;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got || w_hs;
      end
    end
  end

  typedef struct { int idx; logic [7:0] d; } txn_t;
  txn_t stim_q[$];
  txn_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, wr_seen = 0, last_lat = 0, stat_at_wr = 0;
  int   ld_cyc[NR];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    txn_t t;
    t.idx = idx; t.d = d;
    stim_q.push_back(t);
  endtask

  task automatic expect_wr(input int idx, input logic [7:0] d);
    txn_t t;
    t.idx = idx; t.d = d;
    exp_q.push_back(t);
  endtask

  // one cycle: sample at negedge, score writes/ready pulses, drive clients
  task automatic tick();
    txn_t e;
    @(negedge clk);
    cyc++;
    if (wr_cnt != wr_seen) begin
      wr_seen    = wr_cnt;
      stat_at_wr = stat_rd_cnt;
      chk("wr_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("aw_addr", last_aw_addr, BASE + 32'h4);
        chk("w_data", last_w_data, {24'h0, exp_q[0].d});
        chk("w_strb", 32'(last_w_strb), 1);
      end
    end
    if (|req_ready) begin
      chk("rdy_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdy_idx", 32'(req_ready), 32'(1) << e.idx);
        last_lat = cyc - ld_cyc[e.idx];
      end
      req_valid = req_valid & ~req_ready;
    end
    while (stim_q.size() > 0 && !req_valid[stim_q[0].idx]) begin
      e = stim_q.pop_front();
      req_valid[e.idx] = 1'b1;
      req_data[8*e.idx +: 8] = e.d;
      ld_cyc[e.idx] = cyc;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || stim_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("done_in_time", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    stim_q.delete();
    exp_q.delete();
    repeat (3) tick();
    wr_seen = wr_cnt;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base, w0, a0, r0;
    req_valid = '0;
    req_data  = '0;
    rx_ready  = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < NR; i++) ld_cyc[i] = 0;

    // reset state
    repeat (3) tick();
    chk("rst_aw_valid", 32'(axi.aw_valid), 0);
    chk("rst_w_valid", 32'(axi.w_valid), 0);
    chk("rst_ar_valid", 32'(axi.ar_valid), 0);
    chk("rst_r_ready", 32'(axi.r_ready), 0);
    chk("rst_b_ready", 32'(axi.b_ready), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_aw_addr", axi.aw_addr, 0);
    chk("rst_ar_addr", axi.ar_addr, 0);
    chk("rst_w_strb", 32'(axi.w_strb), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single client, minimum latency
    send(0, 8'h41); expect_wr(0, 8'h41);
    wait_done(50);
    chk("lat_single", 32'(last_lat), 5);

    // round robin from rr_ptr = 0, then wrap behaviour
    do_reset();
    send(0, 8'hA0); send(2, 8'hA2); send(3, 8'hA3);
    expect_wr(0, 8'hA0); expect_wr(2, 8'hA2); expect_wr(3, 8'hA3);
    wait_done(100);
    send(2, 8'hB2); send(0, 8'hB0);
    expect_wr(0, 8'hB0); expect_wr(2, 8'hB2);
    wait_done(100);
    send(1, 8'hC1); send(3, 8'hC3);
    expect_wr(3, 8'hC3); expect_wr(1, 8'hC1);
    wait_done(100);

    // TX FIFO full for three status reads
    base = stat_rd_cnt;
    full_until = base + 3;
    send(1, 8'h33); expect_wr(1, 8'h33);
    wait_done(200);
    chk("full_stat_reads", 32'(stat_at_wr - base), 4);

    // AW accepted three cycles after W; SLVERR response
    aw_rdy_en = 1'b0;
    bresp_cfg = 2'b10;
    w0 = w_hs_cnt; a0 = aw_hs_cnt;
    send(0, 8'h77); expect_wr(0, 8'h77);
    n = 0;
    while (w_hs_cnt == w0 && n < 50) begin tick(); n++; end
    chk("w_hs_seen", 32'(w_hs_cnt - w0), 1);
    repeat (3) begin
      chk("aw_held", 32'(axi.aw_valid), 1);
      chk("w_dropped", 32'(axi.w_valid), 0);
      tick();
    end
    aw_rdy_en = 1'b1;
    wait_done(50);
    bresp_cfg = 2'b00;
    chk("w_single", 32'(w_hs_cnt - w0), 1);
    chk("aw_single", 32'(aw_hs_cnt - a0), 1);
    repeat (3) tick();
    chk("err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 0);

`ifdef UART_SCHED_RX_EN
    // RX drain into holding register with back-pressure
    r0 = rx_rd_cnt;
    rx_byte = 8'h5A;
    rx_target = r0 + 1;
    n = 0;
    while (!rx_valid && n < 100) begin tick(); n++; end
    chk("rx_valid", 32'(rx_valid), 1);
    chk("rx_data", 32'(rx_data), 32'h5A);
    rx_byte = 8'hA5;
    rx_target = r0 + 2;
    send(1, 8'h11); expect_wr(1, 8'h11);
    wait_done(100);
    repeat (40) tick();
    chk("rx_no_read", 32'(rx_rd_cnt - r0), 1);
    chk("rx_hold", 32'(rx_data), 32'h5A);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_consumed", 32'(rx_valid), 0);
    n = 0;
    while (!rx_valid && n < 100) begin tick(); n++; end
    chk("rx_valid2", 32'(rx_valid), 1);
    chk("rx_data2", 32'(rx_data), 32'hA5);
    chk("rx_reads", 32'(rx_rd_cnt - r0), 2);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
`else
    r0 = rx_rd_cnt;
    rx_ready = 1'b1;
    repeat (5) tick();
    rx_ready = 1'b0;
    chk("rx_tied_valid", 32'(rx_valid), 0);
    chk("rx_tied_data", 32'(rx_data), 0);
    chk("rx_no_reads", 32'(rx_rd_cnt - r0), 0);
`endif

    // reset while waiting for B: everything drops, no ready pulse
    send(2, 8'h99); expect_wr(2, 8'h99);
    n = 0;
    while (!axi.b_ready && n < 50) begin tick(); n++; end
    chk("in_tx_b", 32'(axi.b_ready), 1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_b_ready", 32'(axi.b_ready), 0);
    chk("rstmid_aw_valid", 32'(axi.aw_valid), 0);
    chk("rstmid_w_valid", 32'(axi.w_valid), 0);
    chk("rstmid_ar_valid", 32'(axi.ar_valid), 0);
    chk("rstmid_r_ready", 32'(axi.r_ready), 0);
    chk("rstmid_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    stim_q.delete();
    exp_q.delete();
    repeat (3) begin
      tick();
      chk("rstmid_no_rdy", 32'(req_ready), 0);
    end
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rstmid_no_rewrite", 32'(wr_cnt - w0), 0);
    chk("bad_addr", 32'(bad_addr_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
